// File: rtl/test_result_monitor_pkg.sv
// rtl/test_result_monitor_pkg.sv - shared state encodings and width defaults for the result monitor
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package test_result_monitor_pkg;

    localparam int DATA_W_DEF = `DATA_WIDTH;
    localparam int REG_AW_DEF = 5;

    localparam logic [2:0] MON_IDLE    = 3'd0;
    localparam logic [2:0] MON_RUN     = 3'd1;
    localparam logic [2:0] MON_SETTLE  = 3'd2;
    localparam logic [2:0] MON_PASS    = 3'd3;
    localparam logic [2:0] MON_FAIL    = 3'd4;
    localparam logic [2:0] MON_TIMEOUT = 3'd5;

endpackage

// File: rtl/test_result_monitor_wb_snoop_reg.sv
// rtl/test_result_monitor_wb_snoop_reg.sv - shadow copy of one register-file entry snooped from write-back
module wb_snoop_reg
    import test_result_monitor_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF,
    parameter int IDX    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture,
    input  logic              clear,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_waddr,
    input  logic [DATA_W-1:0] wb_wdata,
    output logic [DATA_W-1:0] value,
    output logic [DATA_W-1:0] fwd
);

    localparam logic [REG_AW-1:0] IDX_A = REG_AW'(IDX);

    logic hit;

    // x0 is hardwired to zero in the core, so a shadow of it never moves
    assign hit = capture && wb_we && (wb_waddr == IDX_A) && (IDX_A != '0);
    assign fwd = hit ? wb_wdata : value;

    always_ff @(posedge clk) begin
        if (!rst) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (hit) begin
            value <= wb_wdata;
        end
    end

endmodule

// File: rtl/test_result_monitor.sv
// rtl/test_result_monitor.sv - snoops write-back for done/pass/test-number and issues a sticky verdict
module test_result_monitor
    import test_result_monitor_pkg::*;
#(
    parameter int DATA_W         = DATA_W_DEF,
    parameter int REG_AW         = REG_AW_DEF,
    parameter int DONE_REG       = 26,
    parameter int PASS_REG       = 27,
    parameter int TNUM_REG       = 3,
    parameter int DONE_VALUE     = 1,
    parameter int PASS_VALUE     = 1,
    parameter int SETTLE_CYCLES  = 5,
    parameter int TIMEOUT_CYCLES = 2500,
    parameter int CNT_W          = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_waddr,
    input  logic [DATA_W-1:0] wb_wdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [DATA_W-1:0] fail_testnum,
    output logic [CNT_W-1:0]  cycle_count
);

    localparam logic [REG_AW-1:0] DONE_A       = REG_AW'(DONE_REG);
    localparam logic [DATA_W-1:0] DONE_V       = DATA_W'(DONE_VALUE);
    localparam logic [DATA_W-1:0] PASS_V       = DATA_W'(PASS_VALUE);
    localparam bit                NO_SETTLE    = (SETTLE_CYCLES == 0);
    localparam logic [CNT_W-1:0]  SETTLE_LAST  = NO_SETTLE ? '0 : CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]        state;
    logic [CNT_W-1:0]  settle_cnt;
    logic              in_run;
    logic              in_settle;
    logic              active;
    logic              capture;
    logic              done_hit;
    logic              verdict_now;
    logic              pass_now;
    logic              timeout_now;
    logic [DATA_W-1:0] done_val;
    logic [DATA_W-1:0] done_fwd;
    logic [DATA_W-1:0] pass_val;
    logic [DATA_W-1:0] pass_fwd;
    logic [DATA_W-1:0] tnum_val;
    logic [DATA_W-1:0] tnum_fwd;
    logic              unused_shadow;

    assign in_run    = (state == MON_RUN);
    assign in_settle = (state == MON_SETTLE);
    assign active    = in_run || in_settle;
    // start wins over a same-cycle write-back, so shadows only see writes while already armed
    assign capture   = active && !start;

    wb_snoop_reg #(.DATA_W(DATA_W), .REG_AW(REG_AW), .IDX(DONE_REG)) u_done_shadow (
        .clk      (clk),
        .rst      (rst),
        .capture  (capture),
        .clear    (start),
        .wb_we    (wb_we),
        .wb_waddr (wb_waddr),
        .wb_wdata (wb_wdata),
        .value    (done_val),
        .fwd      (done_fwd)
    );

    wb_snoop_reg #(.DATA_W(DATA_W), .REG_AW(REG_AW), .IDX(PASS_REG)) u_pass_shadow (
        .clk      (clk),
        .rst      (rst),
        .capture  (capture),
        .clear    (start),
        .wb_we    (wb_we),
        .wb_waddr (wb_waddr),
        .wb_wdata (wb_wdata),
        .value    (pass_val),
        .fwd      (pass_fwd)
    );

    wb_snoop_reg #(.DATA_W(DATA_W), .REG_AW(REG_AW), .IDX(TNUM_REG)) u_tnum_shadow (
        .clk      (clk),
        .rst      (rst),
        .capture  (capture),
        .clear    (start),
        .wb_we    (wb_we),
        .wb_waddr (wb_waddr),
        .wb_wdata (wb_wdata),
        .value    (tnum_val),
        .fwd      (tnum_fwd)
    );

    assign unused_shadow = ^{done_val, pass_val, tnum_fwd};

    // only an actual write of the done value counts; the forwarded shadow equals wb_wdata on a hit
    assign done_hit    = in_run && wb_we && (wb_waddr == DONE_A) && (DONE_A != '0)
                         && (done_fwd == DONE_V);
    assign verdict_now = (in_settle && (settle_cnt == SETTLE_LAST)) || (NO_SETTLE && done_hit);
    assign pass_now    = (pass_fwd == PASS_V);
    assign timeout_now = active && !verdict_now && !done_hit && (cycle_count == TIMEOUT_LAST);

    assign fail_testnum = tnum_val;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= MON_IDLE;
            settle_cnt  <= '0;
            cycle_count <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            timeout     <= 1'b0;
        end else if (start) begin
            state       <= MON_RUN;
            settle_cnt  <= '0;
            cycle_count <= '0;
            busy        <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            timeout     <= 1'b0;
        end else if (active) begin
            if (cycle_count != '1) begin
                cycle_count <= cycle_count + CNT_W'(1);
            end
            if (verdict_now) begin
                state <= pass_now ? MON_PASS : MON_FAIL;
                busy  <= 1'b0;
                done  <= 1'b1;
                pass  <= pass_now;
                fail  <= !pass_now;
            end else if (timeout_now) begin
                state   <= MON_TIMEOUT;
                busy    <= 1'b0;
                done    <= 1'b1;
                timeout <= 1'b1;
            end else if (done_hit) begin
                state      <= MON_SETTLE;
                settle_cnt <= '0;
            end else if (in_settle) begin
                settle_cnt <= settle_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_test_result_monitor.sv
// tb/tb_test_result_monitor.sv - directed self-checking bench for test_result_monitor
module tb_test_result_monitor;

    logic        clk;
    logic        rst;
    logic        start_a;
    logic        start_t;
    logic        start_z;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;

    logic        busy_a, done_a, pass_a, fail_a, timeout_a;
    logic [31:0] tnum_a, cnt_a;
    logic        busy_t, done_t, pass_t, fail_t, timeout_t;
    logic [31:0] tnum_t, cnt_t;
    logic        busy_z, done_z, pass_z, fail_z, timeout_z;
    logic [31:0] tnum_z, cnt_z;

    int n_cmp = 0;
    int n_bad = 0;

    test_result_monitor dut_a (
        .clk(clk), .rst(rst), .start(start_a),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .busy(busy_a), .done(done_a), .pass(pass_a), .fail(fail_a), .timeout(timeout_a),
        .fail_testnum(tnum_a), .cycle_count(cnt_a)
    );

    test_result_monitor #(.TIMEOUT_CYCLES(100)) dut_t (
        .clk(clk), .rst(rst), .start(start_t),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .busy(busy_t), .done(done_t), .pass(pass_t), .fail(fail_t), .timeout(timeout_t),
        .fail_testnum(tnum_t), .cycle_count(cnt_t)
    );

    test_result_monitor #(.SETTLE_CYCLES(0)) dut_z (
        .clk(clk), .rst(rst), .start(start_z),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .busy(busy_z), .done(done_z), .pass(pass_z), .fail(fail_z), .timeout(timeout_z),
        .fail_testnum(tnum_z), .cycle_count(cnt_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // flag vectors are {busy, done, pass, fail, timeout}
    function automatic logic [31:0] fa();
        return {27'd0, busy_a, done_a, pass_a, fail_a, timeout_a};
    endfunction

    function automatic logic [31:0] ft();
        return {27'd0, busy_t, done_t, pass_t, fail_t, timeout_t};
    endfunction

    function automatic logic [31:0] fz();
        return {27'd0, busy_z, done_z, pass_z, fail_z, timeout_z};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wb_we    = 1'b1;
        wb_waddr = a;
        wb_wdata = d;
        tick();
        wb_we    = 1'b0;
        wb_waddr = 5'd0;
        wb_wdata = 32'd0;
    endtask

    task automatic pulse(input int which);
        if (which == 0) start_a = 1'b1;
        else if (which == 1) start_t = 1'b1;
        else start_z = 1'b1;
        tick();
        start_a = 1'b0;
        start_t = 1'b0;
        start_z = 1'b0;
    endtask

    initial begin
        rst      = 1'b0;
        start_a  = 1'b0;
        start_t  = 1'b0;
        start_z  = 1'b0;
        wb_we    = 1'b0;
        wb_waddr = 5'd0;
        wb_wdata = 32'd0;
        idle(3);
        check("rst_flags_a", fa(), 32'b00000);
        check("rst_cnt_a", cnt_a, 32'd0);
        check("rst_tnum_a", tnum_a, 32'd0);
        check("rst_flags_t", ft(), 32'b00000);
        check("rst_flags_z", fz(), 32'b00000);
        rst = 1'b1;
        idle(2);

        // pass run: done written at cycle 40, verdict after five settle cycles
        pulse(0);
        check("s1_armed", fa(), 32'b10000);
        check("s1_cnt0", cnt_a, 32'd0);
        wr(5'd3, 32'd5);
        wr(5'd27, 32'd1);
        idle(37);
        wr(5'd26, 32'd1);
        check("s1_settle", fa(), 32'b10000);
        check("s1_cnt40", cnt_a, 32'd40);
        idle(4);
        check("s1_pre_verdict", fa(), 32'b10000);
        idle(1);
        check("s1_pass", fa(), 32'b01100);
        check("s1_tnum", tnum_a, 32'd5);
        check("s1_cnt45", cnt_a, 32'd45);

        // fail run, then verdict stays sticky against later writes
        pulse(0);
        check("s2_cleared", fa(), 32'b10000);
        check("s2_tnum_cleared", tnum_a, 32'd0);
        wr(5'd27, 32'd0);
        wr(5'd3, 32'd7);
        wr(5'd26, 32'd1);
        idle(5);
        check("s2_fail", fa(), 32'b01010);
        check("s2_tnum", tnum_a, 32'd7);
        check("s2_cnt", cnt_a, 32'd8);
        wr(5'd27, 32'd1);
        idle(2);
        check("s2_sticky", fa(), 32'b01010);
        check("s2_cnt_frozen", cnt_a, 32'd8);

        // re-arm from FAIL
        pulse(0);
        check("rearm_flags", fa(), 32'b10000);
        wr(5'd27, 32'd1);
        wr(5'd26, 32'd1);
        idle(5);
        check("rearm_pass", fa(), 32'b01100);
        check("rearm_cnt", cnt_a, 32'd7);

        // pass flag written two cycles into SETTLE still counts
        pulse(0);
        wr(5'd26, 32'd1);
        idle(1);
        wr(5'd27, 32'd1);
        idle(3);
        check("s3_late_pass", fa(), 32'b01100);
        check("s3_cnt", cnt_a, 32'd6);

        // pass flag written after the verdict edge does not
        pulse(0);
        wr(5'd26, 32'd1);
        idle(5);
        wr(5'd27, 32'd1);
        check("s3_too_late", fa(), 32'b01010);
        check("s3_tnum_zero", tnum_a, 32'd0);

        // wrong done value and x0 writes leave the monitor running
        pulse(0);
        wr(5'd26, 32'd2);
        idle(7);
        check("corner_done2", fa(), 32'b10000);
        wr(5'd0, 32'd1);
        idle(2);
        check("corner_x0", fa(), 32'b10000);

        // reset mid-SETTLE
        wr(5'd27, 32'd1);
        wr(5'd26, 32'd1);
        idle(2);
        check("mid_settle_busy", fa(), 32'b10000);
        rst = 1'b0;
        tick();
        check("rst_mid_flags", fa(), 32'b00000);
        check("rst_mid_cnt", cnt_a, 32'd0);
        check("rst_mid_tnum", tnum_a, 32'd0);
        rst = 1'b1;
        idle(10);
        check("rst_mid_idle", fa(), 32'b00000);

        // timeout at cycle 100 with no done write
        pulse(1);
        idle(99);
        check("to_pre_flags", ft(), 32'b10000);
        check("to_pre_cnt", cnt_t, 32'd99);
        idle(1);
        check("to_flags", ft(), 32'b01001);
        check("to_cnt", cnt_t, 32'd100);
        idle(3);
        check("to_cnt_frozen", cnt_t, 32'd100);

        // done detection on the timeout edge wins
        pulse(1);
        idle(99);
        wr(5'd26, 32'd1);
        check("to_race_flags", ft(), 32'b10000);
        check("to_race_cnt", cnt_t, 32'd100);
        idle(5);
        check("to_race_verdict", ft(), 32'b01010);
        check("to_race_cnt2", cnt_t, 32'd105);

        // zero settle cycles: verdict on the done edge
        pulse(2);
        wr(5'd27, 32'd1);
        check("z_running", fz(), 32'b10000);
        wr(5'd26, 32'd1);
        check("z_pass", fz(), 32'b01100);
        check("z_cnt", cnt_z, 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
